// File: rtl/sram_like_resp_pkg.sv
// Shared encodings, response-queue entry layout and byte-merge helper for the
// SRAM-like data-port responder.
package sram_like_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int DEF_LATENCY = 2;
    localparam int CNT_W       = 3;   // holds LATENCY-1 for LATENCY up to 7

    typedef struct packed {
        logic             is_write;
        logic [31:0]      rdata;
        logic [CNT_W-1:0] cnt;
    } resp_entry_t;

    localparam int ENTRY_W = $bits(resp_entry_t);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// Circular queue of pending responses; each entry counts down its own latency
// and the head may leave once its counter reaches zero.
module resp_fifo
    import sram_like_pkg::*;
#(
    parameter  int QDEPTH  = 2,
    parameter  int LATENCY = DEF_LATENCY,
    localparam int CW      = $clog2(QDEPTH + 1),
    localparam int PW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_push_wr,
    input  logic [31:0]   i_push_data,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output logic          o_head_ready,
    output logic          o_head_wr,
    output logic [31:0]   o_head_data
);

    resp_entry_t   r_q [QDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    resp_entry_t   w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (i_push && !i_pop)
                r_count <= r_count + CW'(1);
            else if (i_pop && !i_push)
                r_count <= r_count - CW'(1);
        end
    end

    // Entry payload is not reset: a zero count already marks every slot dead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (i_push && r_wr_ptr == PW'(i))
                r_q[i] <= '{is_write: i_push_wr, rdata: i_push_data,
                            cnt: CNT_W'(LATENCY - 1)};
            else if (r_q[i].cnt != '0)
                r_q[i].cnt <= r_q[i].cnt - CNT_W'(1);
        end
    end

    assign w_head       = r_q[r_rd_ptr];
    assign o_count      = r_count;
    assign o_head_ready = (r_count != '0) && (w_head.cnt == '0);
    assign o_head_wr    = w_head.is_write;
    assign o_head_data  = w_head.rdata;

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like data-port responder: byte-strobed writes and word reads on a local
// memory, answered in order after a fixed latency.
module sram_like_resp
    import sram_like_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    input  logic        hold
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]           r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_rd_word;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_head_ready;
    logic                  w_head_wr;
    logic [31:0]           w_head_data;
    logic [CW-1:0]         w_count;
    logic                  w_unused;

    // Size and sub-word offset are the master's business; high bits alias.
    assign w_unused  = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2],
                         data_sram_addr[1:0]};
    assign w_idx     = data_sram_addr[DEPTH_LOG2+1:2];
    assign w_rd_word = r_mem[w_idx];

    assign w_pop             = w_head_ready & ~reset;
    assign data_sram_addr_ok = ~reset & ~hold & ((w_count < CW'(QDEPTH)) | w_pop);
    assign w_accept          = data_sram_req & data_sram_addr_ok;
    assign data_sram_data_ok = w_pop;
    assign data_sram_rdata   = (w_pop & ~w_head_wr) ? w_head_data : '0;

    always_ff @(posedge clk) begin
        if (w_accept && data_sram_wr)
            r_mem[w_idx] <= merge_bytes(w_rd_word, data_sram_wdata, data_sram_wstrb);
    end

    resp_fifo #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_accept),
        .i_push_wr    (data_sram_wr),
        .i_push_data  (data_sram_wr ? 32'd0 : w_rd_word),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head_ready (w_head_ready),
        .o_head_wr    (w_head_wr),
        .o_head_data  (w_head_data)
    );

endmodule
